pwm_demod: RTL
==============

Name: pwm_demod

Overview:
- Receive-side counterpart of the team's PWM modulator.
- Samples a PWM waveform (high at frame start, low for the rest of the frame, fixed frame length) and recovers the per-frame duty value as an 8-bit word.
- Locks frame phase to rising edges, optionally averages over 2^AVG_LOG2 frames, and flags phase slips.
- Sits between the radio front-end comparator / GPIO input and downstream sample consumers.

Parameters:
- PERIOD, 256: frame length in clk cycles; must be ≥ 4 and ≤ 256.
- AVG_LOG2, 0: log2 of the number of frames averaged per output (0..4).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  PWM input, asynchronous to clk.
- dc_out  output  8  recovered duty (count of high samples per frame, averaged).
- valid_out  output  1  one-cycle pulse; dc_out is updated in the same cycle.
- locked  output  1  frame phase established.
- sync_err  output  1  one-cycle pulse when a rising edge arrives off-phase.
- full_high  output  1  one-cycle pulse with valid_out when any averaged frame had every sample high.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: dc_out=0, valid_out=0, locked=0, sync_err=0, full_high=0, state=HUNT, all counters and the accumulator 0.
- Reset asserted mid-frame discards all partial data. The synchronizer flops are also cleared to 0.
- Input path:
  - 2-flop synchronizer produces s; s_d is s delayed one cycle.
  - rise = s & ~s_d.
  - Input-to-s latency is 2 cycles.
- Per-cycle variables:
  - ph: phase index of the current sample, 0..PERIOD-1.
  - hc: high-sample count, 9 bits.
- State HUNT:
  - ph and hc are held at 0; no outputs.
  - On rise: go to LOCKED. That cycle is sample ph=0, so hc := 1.
  - A constant-low or constant-high input never leaves HUNT.
- State LOCKED:
  - locked=1.
  - Every cycle: ph := (ph==PERIOD-1) ? 0 : ph+1; hc accumulates s.
  - A rise in the cycle where the next ph is 0 is the expected frame start: normal.
- Frame end (sample at ph==PERIOD-1):
  - frame_dc = hc including this sample, saturated to 255 (PERIOD=256 all-high gives 255).
  - frame_full = (hc == PERIOD).
  - hc restarts from the next sample.
  - Frames with no rising edge (duty 0 or all-high continuation) are valid frames and do not drop lock.
- Off-phase rise (rise while LOCKED at any ph other than the expected frame start):
  - Pulse sync_err the next cycle.
  - The current sample becomes ph=0, hc := 1.
  - Discard the partial frame and clear the averaging accumulator and frame counter.
  - No valid_out is produced for the discarded data.
  - locked stays 1.
- Averaging:
  - acc (8+AVG_LOG2 bits) sums frame_dc; fcnt counts frames.
  - When fcnt reaches 2^AVG_LOG2-1 and a frame ends: dc_out := (acc + frame_dc) >> AVG_LOG2 (floor).
  - full_high := OR of frame_full over the averaged set.
  - acc and fcnt are cleared.
  - AVG_LOG2=0 gives one output per frame.
- Output timing:
  - valid_out, dc_out and full_high are registered, asserted the cycle after the final sample of the frame.
  - dc_out holds its value between valid pulses.
- Simultaneous events:
  - Off-phase rise on the same cycle a frame would complete: the resync wins and no valid_out is produced.
  - rst has priority over everything.

Test Plan:
- Duty 64, PERIOD=256, repeated 5 frames from reset -> locked rises 3 cycles after the first edge. valid_out pulses every 256 cycles with dc_out=64. No sync_err.
- After lock on duty 100, switch to duty 0 for 3 frames -> dc_out=0 on each of 3 valid pulses 256 cycles apart. locked stays 1. sync_err stays 0.
- sig_in constant 0 (or constant 1) from reset for 2000 cycles -> locked=0, no valid_out.
- Locked on duty 50, inject an extra rising edge at ph=100 -> one sync_err pulse, no valid_out for the interrupted frame. The next valid_out comes 256 cycles after the injected edge (+1 register cycle).
- AVG_LOG2=2, duties 10,20,30,40 -> a single valid_out with dc_out=25. AVG_LOG2=2, duties 1,1,1,2 -> dc_out=1 (floor).
- After lock, hold sig_in high for 2 frames -> dc_out=255 with full_high=1 on each. Assert rst mid-frame -> all outputs 0 next cycle, and the block re-locks on the following rising edge.

Source files
------------

// File: rtl/pwm_demod.sv
// pwm_demod
//   Recovers the duty value of a fixed-length PWM waveform. Each frame starts
//   with the input high and ends low. The block locks its frame phase to rising
//   edges and counts high samples per frame. It can average 2^AVG_LOG2 frames
//   per output, and it reports rising edges that arrive off-phase.
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous, active-high reset (also clears the synchronizer)
//   sig_in    in   PWM input, asynchronous to clk
//   dc_out    out  [7:0] recovered duty, held between valid pulses
//   valid_out out  one-cycle pulse, dc_out/full_high updated in the same cycle
//   locked    out  frame phase established
//   sync_err  out  one-cycle pulse after an off-phase rising edge
//   full_high out  with valid_out: some averaged frame had every sample high
module pwm_demod #(
   parameter int PERIOD   = 256,
   parameter int AVG_LOG2 = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sig_in,
   output logic [7:0] dc_out,
   output logic       valid_out,
   output logic       locked,
   output logic       sync_err,
   output logic       full_high
);

   localparam int ACC_W = 8 + AVG_LOG2;
   localparam int FC_W  = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'((1 << AVG_LOG2) - 1);
   localparam logic [7:0]      PH_LAST = 8'(PERIOD - 1);
   localparam logic [8:0]      HC_FULL = 9'(PERIOD);

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   logic             sync1_q;
   logic             s_q;
   logic             s_dly_q;
   logic [2:0]       fill_q;
   state_e           state_q;
   logic [7:0]       ph_q;
   logic [8:0]       hc_q;
   logic [ACC_W-1:0] acc_q;
   logic [FC_W-1:0]  fcnt_q;
   logic             full_acc_q;
   logic [7:0]       dc_q;
   logic             valid_q;
   logic             sync_err_q;
   logic             full_high_q;

   logic             rise_s;
   logic [8:0]       hc_d;
   logic [7:0]       frame_dc_s;
   logic             frame_full_s;
   logic [ACC_W-1:0] acc_d;
   logic [7:0]       avg_dc_s;

   // Two-flop synchronizer, one-cycle delayed copy, and a fill marker.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         s_dly_q <= 1'b0;
         fill_q  <= 3'b000;
      end else begin
         sync1_q <= sig_in;
         s_q     <= sync1_q;
         s_dly_q <= s_q;
         fill_q  <= {fill_q[1:0], 1'b1};
      end
   end

   // Edge detect and the frame arithmetic for the sample currently in s_q.
   always_comb begin
      // The cleared synchronizer is not a real low level. Without fill_q, an
      // input held high through reset would look like a rising edge.
      rise_s       = s_q & ~s_dly_q & fill_q[2];
      hc_d         = hc_q + {8'b0000_0000, s_q};
      frame_dc_s   = (hc_d > 9'd255) ? 8'hFF : hc_d[7:0];
      frame_full_s = (hc_d == HC_FULL);
      acc_d        = acc_q + ACC_W'(frame_dc_s);
      avg_dc_s     = 8'(acc_d >> AVG_LOG2);
   end

   // Frame-lock FSM with phase/count tracking, averaging and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_HUNT;
         ph_q        <= 8'd0;
         hc_q        <= 9'd0;
         acc_q       <= '0;
         fcnt_q      <= '0;
         full_acc_q  <= 1'b0;
         dc_q        <= 8'd0;
         valid_q     <= 1'b0;
         sync_err_q  <= 1'b0;
         full_high_q <= 1'b0;
      end else begin
         valid_q     <= 1'b0;
         sync_err_q  <= 1'b0;
         full_high_q <= 1'b0;
         case (state_q)
            ST_HUNT: begin
               ph_q <= 8'd0;
               hc_q <= 9'd0;
               if (rise_s) begin
                  // This sample is phase 0 of the first frame, and it is high.
                  state_q <= ST_LOCKED;
                  ph_q    <= 8'd1;
                  hc_q    <= 9'd1;
               end
            end
            ST_LOCKED: begin
               if (rise_s && (ph_q != 8'd0)) begin
                  // Off-phase edge: restart the frame here and drop all partial data.
                  // This branch also takes priority over a frame completing this cycle.
                  sync_err_q <= 1'b1;
                  ph_q       <= 8'd1;
                  hc_q       <= 9'd1;
                  acc_q      <= '0;
                  fcnt_q     <= '0;
                  full_acc_q <= 1'b0;
               end else if (ph_q == PH_LAST) begin
                  ph_q <= 8'd0;
                  hc_q <= 9'd0;
                  if (fcnt_q == FC_LAST) begin
                     valid_q     <= 1'b1;
                     dc_q        <= avg_dc_s;
                     full_high_q <= full_acc_q | frame_full_s;
                     acc_q       <= '0;
                     fcnt_q      <= '0;
                     full_acc_q  <= 1'b0;
                  end else begin
                     acc_q      <= acc_d;
                     fcnt_q     <= fcnt_q + FC_W'(1);
                     full_acc_q <= full_acc_q | frame_full_s;
                  end
               end else begin
                  ph_q <= ph_q + 8'd1;
                  hc_q <= hc_d;
               end
            end
            default: begin
               state_q <= ST_HUNT;
            end
         endcase
      end
   end

   assign dc_out    = dc_q;
   assign valid_out = valid_q;
   assign locked    = (state_q == ST_LOCKED);
   assign sync_err  = sync_err_q;
   assign full_high = full_high_q;

endmodule
